// File: rtl/exec_pkg.sv
// Shared types for the execute/memory/write-back backend.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package exec_pkg;

   // Widths of the packed pipeline records. Override these together with the
   // DATA_WIDTH / NUM_REGS parameters of exec_backend.
   localparam int EXEC_DATA_WIDTH = 32;
   localparam int EXEC_NUM_REGS   = 32;
   localparam int EXEC_REG_AW     = $clog2(EXEC_NUM_REGS);

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10,
      RES_ALU2 = 2'b11
   } result_src_e;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'b00,
      SZ_HALF  = 2'b01,
      SZ_WORD  = 2'b10,
      SZ_WORD2 = 2'b11
   } mem_size_e;

   // E/M pipeline register
   typedef struct packed {
      logic                       valid;
      logic [EXEC_REG_AW-1:0]     rd;
      logic                       RegWrite;
      logic                       MemRead;
      logic                       MemWrite;
      mem_size_e                  MemSize;
      logic                       MemUnsigned;
      result_src_e                ResultSrc;
      logic [EXEC_DATA_WIDTH-1:0] alu_result;
      logic [EXEC_DATA_WIDTH-1:0] store_data;
      logic [EXEC_DATA_WIDTH-1:0] pc_plus4;
   } em_reg_t;

   // M/W pipeline register
   typedef struct packed {
      logic                       valid;
      logic [EXEC_REG_AW-1:0]     rd;
      logic                       RegWrite;
      logic [EXEC_DATA_WIDTH-1:0] result;
   } mw_reg_t;

   // Half accesses need addr[0]==0, word accesses (including size 11) addr[1:0]==0.
   function automatic logic is_misaligned(input mem_size_e sz, input logic [1:0] a);
      logic mis;
      case (sz)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = a[0];
         default: mis = |a;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/exec_backend_if.sv
// Decode-to-backend bundle plus backend status/write-back outputs.
// Latency: n/a (wiring only).
// Backpressure: stall tells the decode side to hold the current bundle.
interface exec_backend_if #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_AW     = 5
);
   logic                  in_valid;
   logic [REG_AW-1:0]     rs1;
   logic [REG_AW-1:0]     rs2;
   logic [REG_AW-1:0]     rd;
   logic [DATA_WIDTH-1:0] ImmExt;
   logic [DATA_WIDTH-1:0] PCPlus4;
   logic                  AluSrc;
   logic [2:0]            ALUControl;
   logic                  RegWrite;
   logic                  MemWrite;
   logic                  MemRead;
   logic [1:0]            MemSize;
   logic                  MemUnsigned;
   logic [1:0]            ResultSrc;
   logic                  stall;
   logic                  zero;
   logic                  wb_valid;
   logic [REG_AW-1:0]     wb_rd;
   logic [DATA_WIDTH-1:0] wb_data;
   logic                  misalign;

   modport master (
      output in_valid, rs1, rs2, rd, ImmExt, PCPlus4, AluSrc, ALUControl,
             RegWrite, MemWrite, MemRead, MemSize, MemUnsigned, ResultSrc,
      input  stall, zero, wb_valid, wb_rd, wb_data, misalign
   );

   modport slave (
      input  in_valid, rs1, rs2, rd, ImmExt, PCPlus4, AluSrc, ALUControl,
             RegWrite, MemWrite, MemRead, MemSize, MemUnsigned, ResultSrc,
      output stall, zero, wb_valid, wb_rd, wb_data, misalign
   );
endinterface

// File: rtl/exec_regfile.sv
// Architectural register file, two async read ports, one write port, x0 reads 0.
// Latency: reads combinational, write lands on the clock edge.
// Backpressure: none; always accepts the write.
module exec_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int AW         = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [AW-1:0]         raddr1,
   input  logic [AW-1:0]         raddr2,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata
);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   // Register storage: cleared on reset, x0 is never written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/exec_backend.sv
// Three-stage backend: E (regfile read, forwarding, ALU), M (byte-addressed data memory), W (write-back).
// Latency: bundle accepted at edge k, wb_* valid in cycle k+1..k+2, regfile written at edge k+2.
// Backpressure: stall for one cycle on a load-use hazard; a bubble enters E/M and upstream holds the bundle.
module exec_backend
   import exec_pkg::*;
#(
   parameter int DATA_WIDTH     = EXEC_DATA_WIDTH,
   parameter int NUM_REGS       = EXEC_NUM_REGS,
   parameter int MEM_ADDR_WIDTH = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   exec_backend_if.slave bus
);

   localparam int RAW = $clog2(NUM_REGS);
   localparam int SHW = $clog2(DATA_WIDTH);
   localparam int MAW = MEM_ADDR_WIDTH;

   em_reg_t em_q;
   mw_reg_t mw_q;

   logic [DATA_WIDTH-1:0] rf_rdata1, rf_rdata2;
   logic [DATA_WIDTH-1:0] op_a, op_b, src_b, alu_res, em_result;
   logic                  em_fwd_ok, mw_fwd_ok, stall;

   // ---------------- E stage ----------------
   exec_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .AW         (RAW)
   ) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .raddr1 (bus.rs1),
      .raddr2 (bus.rs2),
      .rdata1 (rf_rdata1),
      .rdata2 (rf_rdata2),
      .we     (mw_q.valid && mw_q.RegWrite),
      .waddr  (mw_q.rd),
      .wdata  (mw_q.result)
   );

   // Loads in E/M have no data yet, so only non-loads forward from there
   assign em_fwd_ok = em_q.valid && em_q.RegWrite && !em_q.MemRead;
   assign mw_fwd_ok = mw_q.valid && mw_q.RegWrite;
   assign em_result = (em_q.ResultSrc == RES_PC4) ? em_q.pc_plus4 : em_q.alu_result;

   // Operand select: x0 first, then the younger E/M result, then W, then the regfile
   always_comb begin
      op_a = rf_rdata1;
      if (bus.rs1 == '0)                        op_a = '0;
      else if (em_fwd_ok && em_q.rd == bus.rs1) op_a = em_result;
      else if (mw_fwd_ok && mw_q.rd == bus.rs1) op_a = mw_q.result;
      op_b = rf_rdata2;
      if (bus.rs2 == '0)                        op_b = '0;
      else if (em_fwd_ok && em_q.rd == bus.rs2) op_b = em_result;
      else if (mw_fwd_ok && mw_q.rd == bus.rs2) op_b = mw_q.result;
   end

   assign src_b = bus.AluSrc ? bus.ImmExt : op_b;

   // ALU; every result wraps to DATA_WIDTH bits
   always_comb begin
      alu_res = '0;
      case (alu_op_e'(bus.ALUControl))
         ALU_ADD: alu_res = op_a + src_b;
         ALU_SUB: alu_res = op_a - src_b;
         ALU_AND: alu_res = op_a & src_b;
         ALU_OR:  alu_res = op_a | src_b;
         ALU_XOR: alu_res = op_a ^ src_b;
         ALU_SLT: alu_res[0] = $signed(op_a) < $signed(src_b);
         ALU_SLL: alu_res = op_a << src_b[SHW-1:0];
         ALU_SRL: alu_res = op_a >> src_b[SHW-1:0];
         default: alu_res = '0;
      endcase
   end

   // Load-use: the consumer waits one cycle so the load result can come from M/W
   assign stall = bus.in_valid && em_q.valid && em_q.MemRead && em_q.RegWrite &&
                  (em_q.rd != '0) && ((em_q.rd == bus.rs1) || (em_q.rd == bus.rs2));

   assign bus.stall = stall;
   assign bus.zero  = bus.in_valid && !stall && (alu_res == '0);

   // E/M register: a stalled or invalid slot becomes a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         em_q <= '0;
      end else begin
         em_q.valid       <= bus.in_valid && !stall;
         em_q.rd          <= bus.rd;
         em_q.RegWrite    <= bus.RegWrite;
         em_q.MemRead     <= bus.MemRead;
         em_q.MemWrite    <= bus.MemWrite;
         em_q.MemSize     <= mem_size_e'(bus.MemSize);
         em_q.MemUnsigned <= bus.MemUnsigned;
         em_q.ResultSrc   <= result_src_e'(bus.ResultSrc);
         em_q.alu_result  <= alu_res;
         em_q.store_data  <= op_b;
         em_q.pc_plus4    <= bus.PCPlus4;
      end
   end

   // ---------------- M stage ----------------
   logic [7:0]            mem [2**MAW];
   logic [MAW-1:0]        m_addr, m_a1, m_a2, m_a3;
   logic                  m_mis, m_acc, m_st_en, sbit;
   logic [DATA_WIDTH-1:0] ld_data, m_result;

   assign m_addr  = em_q.alu_result[MAW-1:0];
   assign m_a1    = m_addr | MAW'(1);
   assign m_a2    = m_addr | MAW'(2);
   assign m_a3    = m_addr | MAW'(3);
   assign m_mis   = is_misaligned(em_q.MemSize, m_addr[1:0]);
   assign m_acc   = em_q.valid && (em_q.MemRead || em_q.MemWrite);
   assign m_st_en = em_q.valid && em_q.MemWrite && !m_mis;

   assign bus.misalign = m_acc && m_mis;

   // Little-endian store of 1, 2 or 4 bytes; aligned so OR-ing the low bits equals adding
   always_ff @(posedge clk) begin
      if (m_st_en) begin
         mem[m_addr] <= em_q.store_data[7:0];
         if (em_q.MemSize != SZ_BYTE) mem[m_a1] <= em_q.store_data[15:8];
         if (em_q.MemSize[1]) begin
            mem[m_a2] <= em_q.store_data[23:16];
            mem[m_a3] <= em_q.store_data[31:24];
         end
      end
   end

   // Load extraction with sign/zero extension; misaligned loads read as 0
   always_comb begin
      ld_data = '0;
      sbit    = 1'b0;
      if (!m_mis) begin
         case (em_q.MemSize)
            SZ_BYTE: begin
               sbit          = !em_q.MemUnsigned && mem[m_addr][7];
               ld_data       = {DATA_WIDTH{sbit}};
               ld_data[7:0]  = mem[m_addr];
            end
            SZ_HALF: begin
               sbit          = !em_q.MemUnsigned && mem[m_a1][7];
               ld_data       = {DATA_WIDTH{sbit}};
               ld_data[15:0] = {mem[m_a1], mem[m_addr]};
            end
            default: begin
               sbit          = !em_q.MemUnsigned && mem[m_a3][7];
               ld_data       = {DATA_WIDTH{sbit}};
               ld_data[31:0] = {mem[m_a3], mem[m_a2], mem[m_a1], mem[m_addr]};
            end
         endcase
      end
   end

   // Final result selection for the W stage
   always_comb begin
      case (em_q.ResultSrc)
         RES_LOAD: m_result = ld_data;
         RES_PC4:  m_result = em_q.pc_plus4;
         default:  m_result = em_q.alu_result;
      endcase
   end

   // ---------------- W stage ----------------
   // M/W register: x0 and non-writing instructions carry a zero result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mw_q <= '0;
      end else begin
         mw_q.valid    <= em_q.valid;
         mw_q.rd       <= em_q.rd;
         mw_q.RegWrite <= em_q.RegWrite;
         mw_q.result   <= (em_q.RegWrite && (em_q.rd != '0)) ? m_result : '0;
      end
   end

   assign bus.wb_valid = mw_q.valid;
   assign bus.wb_rd    = mw_q.rd;
   assign bus.wb_data  = mw_q.result;

endmodule
